// File: rtl/mem_port_arbiter.sv
// Shared backing-memory port arbiter: fetch refill vs. load/store, one transaction in flight.
// Optional `ARB_PERF_CNT_EN adds grant and conflict-cycle performance counters.
module mem_port_arbiter #(
    parameter int unsigned ADDR_W       = 32,
    parameter int unsigned DATA_W       = 32,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic                clk_i,
    input  logic                reset_i,
    // Fetch side
    input  logic                if_req_i,
    input  logic [ADDR_W-1:0]   if_addr_i,
    output logic                if_ready_o,
    output logic                if_rvalid_o,
    output logic [DATA_W-1:0]   if_rdata_o,
    // Load/store side
    input  logic                ls_req_i,
    input  logic                ls_we_i,
    input  logic [ADDR_W-1:0]   ls_addr_i,
    input  logic [DATA_W-1:0]   ls_wdata_i,
    input  logic [DATA_W/8-1:0] ls_be_i,
    output logic                ls_ready_o,
    output logic                ls_rvalid_o,
    output logic [DATA_W-1:0]   ls_rdata_o,
    // Memory side
    output logic                mem_req_o,
    output logic                mem_we_o,
    output logic [ADDR_W-1:0]   mem_addr_o,
    output logic [DATA_W-1:0]   mem_wdata_o,
    output logic [DATA_W/8-1:0] mem_be_o,
    input  logic                mem_ready_i,
    input  logic                mem_rvalid_i,
    input  logic [DATA_W-1:0]   mem_rdata_i
`ifdef ARB_PERF_CNT_EN
    ,
    output logic [31:0]         perf_if_grants_o,
    output logic [31:0]         perf_ls_grants_o,
    output logic [31:0]         perf_conflict_cycles_o
`endif
);

    localparam int unsigned BE_W  = DATA_W / 8;
    localparam int unsigned CNT_W = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(STARVE_LIMIT);
    localparam bit               STARVE_EN = (STARVE_LIMIT > 0);

    typedef enum logic [1:0] {StIdle, StIssue, StResp} state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   starve_q, starve_d;
    logic               owner_ls_q, owner_ls_d;
    logic               req_we_q, req_we_d;
    logic [ADDR_W-1:0]  req_addr_q, req_addr_d;
    logic [DATA_W-1:0]  req_wdata_q, req_wdata_d;
    logic [BE_W-1:0]    req_be_q, req_be_d;
    logic               if_rvalid_q, if_rvalid_d;
    logic               ls_rvalid_q, ls_rvalid_d;
    logic [DATA_W-1:0]  if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0]  ls_rdata_q, ls_rdata_d;

    logic starve_force;
    logic fetch_wins;
    logic if_grant;
    logic ls_grant;

    // Fetch is forced through only once the data side has won STARVE_LIMIT times in a row.
    assign starve_force = STARVE_EN && (starve_q == CNT_MAX);
    assign fetch_wins   = if_req_i && (!ls_req_i || starve_force);

    always_comb begin
        state_d     = state_q;
        starve_d    = starve_q;
        owner_ls_d  = owner_ls_q;
        req_we_d    = req_we_q;
        req_addr_d  = req_addr_q;
        req_wdata_d = req_wdata_q;
        req_be_d    = req_be_q;
        if_rvalid_d = 1'b0;
        ls_rvalid_d = 1'b0;
        if_rdata_d  = if_rdata_q;
        ls_rdata_d  = ls_rdata_q;
        if_grant    = 1'b0;
        ls_grant    = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (if_req_i || ls_req_i) begin
                    state_d = StIssue;
                    if (fetch_wins) begin
                        if_grant    = 1'b1;
                        owner_ls_d  = 1'b0;
                        req_we_d    = 1'b0;
                        req_addr_d  = if_addr_i;
                        req_wdata_d = '0;
                        req_be_d    = '1;
                        starve_d    = '0;
                    end else begin
                        ls_grant    = 1'b1;
                        owner_ls_d  = 1'b1;
                        req_we_d    = ls_we_i;
                        req_addr_d  = ls_addr_i;
                        req_wdata_d = ls_wdata_i;
                        req_be_d    = ls_be_i;
                        if (if_req_i && (starve_q != CNT_MAX)) begin
                            starve_d = starve_q + CNT_W'(1);
                        end
                    end
                end
            end
            StIssue: begin
                if (mem_ready_i) begin
                    state_d = req_we_q ? StIdle : StResp;
                end
            end
            StResp: begin
                if (mem_rvalid_i) begin
                    state_d = StIdle;
                    if (owner_ls_q) begin
                        ls_rvalid_d = 1'b1;
                        ls_rdata_d  = mem_rdata_i;
                    end else begin
                        if_rvalid_d = 1'b1;
                        if_rdata_d  = mem_rdata_i;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q     <= StIdle;
            starve_q    <= '0;
            owner_ls_q  <= 1'b0;
            req_we_q    <= 1'b0;
            req_addr_q  <= '0;
            req_wdata_q <= '0;
            req_be_q    <= '0;
            if_rvalid_q <= 1'b0;
            ls_rvalid_q <= 1'b0;
            if_rdata_q  <= '0;
            ls_rdata_q  <= '0;
        end else begin
            state_q     <= state_d;
            starve_q    <= starve_d;
            owner_ls_q  <= owner_ls_d;
            req_we_q    <= req_we_d;
            req_addr_q  <= req_addr_d;
            req_wdata_q <= req_wdata_d;
            req_be_q    <= req_be_d;
            if_rvalid_q <= if_rvalid_d;
            ls_rvalid_q <= ls_rvalid_d;
            if_rdata_q  <= if_rdata_d;
            ls_rdata_q  <= ls_rdata_d;
        end
    end

    // Grants are combinational from IDLE, so mask them while reset is held.
    assign if_ready_o  = if_grant && !reset_i;
    assign ls_ready_o  = ls_grant && !reset_i;
    assign if_rvalid_o = if_rvalid_q;
    assign ls_rvalid_o = ls_rvalid_q;
    assign if_rdata_o  = if_rdata_q;
    assign ls_rdata_o  = ls_rdata_q;

    assign mem_req_o   = (state_q == StIssue) && !reset_i;
    assign mem_we_o    = req_we_q;
    assign mem_addr_o  = req_addr_q;
    assign mem_wdata_o = req_wdata_q;
    assign mem_be_o    = req_be_q;

`ifdef ARB_PERF_CNT_EN
    logic [31:0] perf_if_q, perf_ls_q, perf_conflict_q;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            perf_if_q       <= '0;
            perf_ls_q       <= '0;
            perf_conflict_q <= '0;
        end else begin
            if (if_grant) perf_if_q <= perf_if_q + 32'd1;
            if (ls_grant) perf_ls_q <= perf_ls_q + 32'd1;
            if ((state_q == StIdle) && if_req_i && ls_req_i) begin
                perf_conflict_q <= perf_conflict_q + 32'd1;
            end
        end
    end

    assign perf_if_grants_o       = perf_if_q;
    assign perf_ls_grants_o       = perf_ls_q;
    assign perf_conflict_cycles_o = perf_conflict_q;
`endif

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Arbitrates between instruction-fetch refill and load/store requests for the core's single shared backing-memory port.
- Sits between the fetch/LSU stage logic and the unified memory model below `riscv_top`.
- Allows one outstanding transaction at a time.
- Data side has fixed priority, with a bounded anti-starvation override for fetch.

Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width
- STARVE_LIMIT, 4, consecutive data grants made while fetch is waiting before fetch is forced to win; 0 = pure data priority

Ports:
- clk_i  in  1  clock
- reset_i  in  1  asynchronous active-high reset
- if_req_i  in  1  fetch read request; held with stable address until if_ready_o
- if_addr_i  in  ADDR_W  fetch address
- if_ready_o  out  1  fetch request accepted, one-cycle pulse
- if_rvalid_o  out  1  fetch read data valid, one-cycle pulse
- if_rdata_o  out  DATA_W  fetch read data
- ls_req_i  in  1  load/store request; held with stable fields until ls_ready_o
- ls_we_i  in  1  1 = store
- ls_addr_i  in  ADDR_W  load/store address
- ls_wdata_i  in  DATA_W  store data
- ls_be_i  in  DATA_W/8  store byte enables
- ls_ready_o  out  1  load/store request accepted, one-cycle pulse
- ls_rvalid_o  out  1  load data valid, one-cycle pulse
- ls_rdata_o  out  DATA_W  load data
- mem_req_o  out  1  memory request
- mem_we_o  out  1  memory write enable
- mem_addr_o  out  ADDR_W  memory address
- mem_wdata_o  out  DATA_W  memory write data
- mem_be_o  out  DATA_W/8  memory byte enables
- mem_ready_i  in  1  memory accepts request this cycle
- mem_rvalid_i  in  1  memory read data valid
- mem_rdata_i  in  DATA_W  memory read data

Behaviour:
- Clocking: single clock, clk_i. Reset is asynchronous and active-high on reset_i.
- Reset forces:
  - state=IDLE, starve_cnt=0
  - all *_ready_o, *_rvalid_o and mem_req_o = 0
  - all data, address and byte-enable outputs = 0
- FSM states: IDLE, ISSUE, RESP.
- IDLE:
  - If any request is present, select a winner, latch its fields into the request register, assert the winner's *_ready_o combinationally this cycle, and go to ISSUE.
  - Loads from fetch latch we=0 and be=all-ones.
- Selection rule:
  - ls_req_i wins, unless if_req_i=1 and starve_cnt==STARVE_LIMIT with STARVE_LIMIT>0; in that case fetch wins.
  - The loser sees no ready and must hold its request.
- Starvation counter:
  - Increments on each data grant while if_req_i=1.
  - Clears on any fetch grant.
  - Saturates at STARVE_LIMIT.
  - Width is $clog2(STARVE_LIMIT+1), minimum 1.
- ISSUE:
  - mem_req_o=1; mem_we_o, mem_addr_o, mem_wdata_o and mem_be_o are driven from the latched request and stay stable until mem_ready_i.
  - On mem_ready_i, a store goes to IDLE and a load goes to RESP.
- RESP:
  - mem_req_o=0.
  - On mem_rvalid_i, register mem_rdata_i into the owner's rdata_o and pulse the owner's rvalid_o for exactly one cycle, on the following cycle. Go to IDLE.
  - The non-owner's rvalid_o stays 0.
  - rdata_o holds its last value between responses.
- No new grant is made in ISSUE or RESP. The earliest regrant is the IDLE cycle after completion.
- Store completion:
  - No response is returned for a store.
  - The next IDLE cycle may grant again.
- Minimum read latency: accept at cycle N, mem_ready_i at N+1, mem_rvalid_i at N+2, *_rvalid_o at N+3.
- Reset asserted mid-transaction aborts it immediately:
  - mem_req_o drops asynchronously.
  - No rvalid is produced.
  - Any memory response arriving after reset deassertion while in IDLE is ignored.
- mem_rvalid_i or mem_ready_i arriving in an unexpected state is ignored.

Optional Feature:
- Macro: ARB_PERF_CNT_EN.
- When defined, three 32-bit wrapping counters are added, each cleared by reset and exported on ports perf_if_grants_o, perf_ls_grants_o and perf_conflict_cycles_o:
  - fetch grants
  - load/store grants
  - conflict cycles, i.e. IDLE cycles with both requests present
- When undefined, these ports and counters do not exist, and all other behaviour is identical.

Test Plan:
- Fetch only, if_addr_i=0x100, mem_ready_i=1 immediately, mem_rvalid_i next cycle with 0xDEADBEEF -> if_ready_o pulse at N, mem_addr_o=0x100 at N+1, if_rvalid_o=1 with if_rdata_o=0xDEADBEEF at N+3, ls_rvalid_o stays 0.
- Store only, addr 0x200, wdata 0x12345678, be 0b0011, mem_ready_i delayed 3 cycles -> mem_* fields stay stable all 3 wait cycles, no rvalid pulse, ls_ready_o pulses once.
- Both requesting continuously, STARVE_LIMIT=4 -> grant order is D,D,D,D,I,D,D,D,D,I; starve_cnt clears after each fetch grant.
- STARVE_LIMIT=0, both requesting continuously for 10 grants -> all 10 are data grants, if_ready_o never asserts.
- Reset asserted in RESP, then mem_rvalid_i=1 after release -> no rvalid on either side, state IDLE, mem_req_o=0 during reset.
- ARB_PERF_CNT_EN defined, running the 10-grant contention scenario above -> perf_ls_grants_o=8, perf_if_grants_o=2, perf_conflict_cycles_o=10.
